// File: rtl/motor_pwm_ctrl_if.sv
// rtl/motor_pwm_ctrl_if.sv - command and bridge-drive bundle for motor_pwm_ctrl
interface motor_pwm_ctrl_if #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 4
);
    logic [CHANNELS*CNT_W-1:0] duty_cmd;
    logic [CHANNELS-1:0]       dir_cmd;
    logic [CHANNELS-1:0]       pwm;
    logic [CHANNELS-1:0]       in1;
    logic [CHANNELS-1:0]       in2;
    logic [CHANNELS-1:0]       busy;

    modport master (
        output duty_cmd, dir_cmd,
        input  pwm, in1, in2, busy
    );

    modport slave (
        input  duty_cmd, dir_cmd,
        output pwm, in1, in2, busy
    );
endinterface

// File: rtl/motor_pwm_ctrl.sv
// rtl/motor_pwm_ctrl.sv - multi-channel H-bridge PWM with duty ramping and dead time on reversal
module motor_pwm_ctrl #(
    parameter int CHANNELS    = 2,
    parameter int CNT_W       = 4,
    parameter int PERIOD      = 10,
    parameter int RAMP_DIV    = 1,
    parameter int DEAD_CYCLES = 20
) (
    input  logic             clk,
    input  logic             rst,
    motor_pwm_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN, RAMP_DN, DEAD} state_t;

    localparam int RW = $clog2(RAMP_DIV) + 1;
    localparam int DW = $clog2(DEAD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] PER_V  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] PER_M1 = CNT_W'(PERIOD - 1);
    localparam logic [RW-1:0]    RAMP_LAST = RW'(RAMP_DIV - 1);
    localparam logic [DW-1:0]    DEAD_LAST = DW'(DEAD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    state_t           state_q [CHANNELS];
    state_t           state_d [CHANNELS];
    logic [CNT_W-1:0] duty_q  [CHANNELS];
    logic [CNT_W-1:0] duty_d  [CHANNELS];
    logic [CNT_W-1:0] tgt     [CHANNELS];
    logic [CNT_W-1:0] cmd     [CHANNELS];
    logic [RW-1:0]    ramp_q  [CHANNELS];
    logic [RW-1:0]    ramp_d  [CHANNELS];
    logic [DW-1:0]    dead_q  [CHANNELS];
    logic [DW-1:0]    dead_d  [CHANNELS];
    logic [CHANNELS-1:0] dir_q, dir_d, mism;
    logic [CHANNELS-1:0] pwm_q, pwm_d, in1_q, in1_d, in2_q, in2_d, busy_v;

    assign wrap = (cnt == PER_M1);

    // Shared period counter, 0..PERIOD-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

    // Per-channel next state: ramp duty at wraps, sequence reversal through ramp-down and dead time.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            duty_d[i]  = duty_q[i];
            ramp_d[i]  = ramp_q[i];
            dead_d[i]  = dead_q[i];
            dir_d[i]   = dir_q[i];
            mism[i]    = (bus.dir_cmd[i] != dir_q[i]);
            cmd[i]     = bus.duty_cmd[i*CNT_W +: CNT_W];
            // A pending reversal pulls the target to zero even before RAMP_DN is entered.
            tgt[i]     = '0;
            if (state_q[i] == RUN && !mism[i]) begin
                tgt[i] = (cmd[i] > PER_V) ? PER_V : cmd[i];
            end

            if (wrap && state_q[i] != DEAD) begin
                if (ramp_q[i] == RAMP_LAST) begin
                    ramp_d[i] = '0;
                    if (duty_q[i] < tgt[i]) begin
                        duty_d[i] = duty_q[i] + CNT_W'(1);
                    end else if (duty_q[i] > tgt[i]) begin
                        duty_d[i] = duty_q[i] - CNT_W'(1);
                    end
                end else begin
                    ramp_d[i] = ramp_q[i] + RW'(1);
                end
            end

            case (state_q[i])
                RUN: begin
                    if (mism[i]) begin
                        state_d[i] = (duty_q[i] != '0) ? RAMP_DN : DEAD;
                    end
                end
                RAMP_DN: begin
                    if (!mism[i]) begin
                        state_d[i] = RUN;
                    end else if (duty_q[i] == '0) begin
                        state_d[i] = DEAD;
                    end
                end
                DEAD: begin
                    duty_d[i] = '0;
                    ramp_d[i] = '0;
                    if (dead_q[i] == DEAD_LAST) begin
                        state_d[i] = RUN;
                        dir_d[i]   = bus.dir_cmd[i];
                        dead_d[i]  = '0;
                    end else begin
                        dead_d[i]  = dead_q[i] + DW'(1);
                    end
                end
                default: state_d[i] = RUN;
            endcase

            if (state_d[i] == DEAD && state_q[i] != DEAD) begin
                dead_d[i] = '0;
                duty_d[i] = '0;
                ramp_d[i] = '0;
            end

            pwm_d[i] = (state_q[i] != DEAD) && (cnt < duty_q[i]);
            in1_d[i] = (state_d[i] != DEAD) && dir_d[i];
            in2_d[i] = (state_d[i] != DEAD) && !dir_d[i];
            busy_v[i] = (state_q[i] != RUN);
        end
    end

    // Per-channel state and registered bridge outputs.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (rst) begin
                state_q[i] <= RUN;
                duty_q[i]  <= '0;
                ramp_q[i]  <= '0;
                dead_q[i]  <= '0;
                dir_q[i]   <= 1'b1;
                pwm_q[i]   <= 1'b0;
                in1_q[i]   <= 1'b1;
                in2_q[i]   <= 1'b0;
            end else begin
                state_q[i] <= state_d[i];
                duty_q[i]  <= duty_d[i];
                ramp_q[i]  <= ramp_d[i];
                dead_q[i]  <= dead_d[i];
                dir_q[i]   <= dir_d[i];
                pwm_q[i]   <= pwm_d[i];
                in1_q[i]   <= in1_d[i];
                in2_q[i]   <= in2_d[i];
            end
        end
    end

    assign bus.pwm  = pwm_q;
    assign bus.in1  = in1_q;
    assign bus.in2  = in2_q;
    assign bus.busy = busy_v;
endmodule
